// File: rtl/mux16_rr_sched_pkg.sv
// Shared definitions for the 16-requester round-robin mux scheduler:
// FSM encodings and default sizing.
package mux16_rr_sched_pkg;

    typedef logic [0:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 1'b0;
    localparam sched_state_t ST_GRANT = 1'b1;

    localparam int N_DEF        = 16;
    localparam int SEL_W_DEF    = 4;
    localparam int MAX_HOLD_DEF = 15;

endpackage

// File: rtl/mux16_rr_sched_pick.sv
// Combinational round-robin pick: first set request at or above last+1,
// wrapping past N-1 back to 0.
module rr_pick16
    import mux16_rr_sched_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] N_W    = (SEL_W+1)'(N);
    localparam logic [SEL_W:0] LAST_W = (SEL_W+1)'(N - 1);

    logic [SEL_W:0]   start_s;
    logic [2*N-1:0]   rot_s;
    logic [N-1:0]     rot_low_s;
    logic [SEL_W:0]   off_s;
    logic [SEL_W:0]   sum_s;
    logic             found_s;

    // Rotate so the search start lands at bit 0, priority-encode, then undo the rotation.
    always_comb begin
        any       = |req;
        start_s   = '0;
        rot_s     = '0;
        rot_low_s = '0;
        off_s     = '0;
        sum_s     = '0;
        found_s   = 1'b0;
        idx       = '0;

        if ({1'b0, last} >= LAST_W) begin
            start_s = '0;
        end else begin
            start_s = {1'b0, last} + (SEL_W+1)'(1);
        end

        rot_s     = {req, req} >> start_s;
        rot_low_s = rot_s[N-1:0];

        for (int i = 0; i < N; i++) begin
            if (!found_s && rot_low_s[i]) begin
                off_s   = (SEL_W+1)'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end

        sum_s = start_s + off_s;
        if (sum_s >= N_W) begin
            sum_s = sum_s - N_W;
        end else begin
            sum_s = sum_s;
        end
        idx = sum_s[SEL_W-1:0];
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving the select of a 16:1 mux; holds a grant
// until done, withdrawal or hold timeout, with one idle cycle between grants.
module mux16_rr_sched
    import mux16_rr_sched_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic [N-1:0]     gnt,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0]     ONE_HOT0  = N'(1);

    sched_state_t      state_r, state_nxt_s;
    logic [SEL_W-1:0]  sel_r, sel_nxt_s;
    logic [SEL_W-1:0]  last_r, last_nxt_s;
    logic [N-1:0]      gnt_r, gnt_nxt_s;
    logic              gv_r, gv_nxt_s;
    logic              to_r, to_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              pick_any_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic              release_s;
    logic              expire_s;

    rr_pick16 #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req  (req),
        .last (last_r),
        .any  (pick_any_s),
        .idx  (pick_idx_s)
    );

    assign release_s = done || !req[sel_r];
    assign expire_s  = (MAX_HOLD != 0) && (cnt_r == HOLD_LAST);

    // Next-state logic: arbitrate in IDLE, watch release conditions in GRANT.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        last_nxt_s  = last_r;
        gnt_nxt_s   = gnt_r;
        gv_nxt_s    = gv_r;
        cnt_nxt_s   = cnt_r;
        to_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = ST_GRANT;
                    sel_nxt_s   = pick_idx_s;
                    last_nxt_s  = pick_idx_s;
                    gnt_nxt_s   = ONE_HOT0 << pick_idx_s;
                    gv_nxt_s    = 1'b1;
                    cnt_nxt_s   = '0;
                end else begin
                    gnt_nxt_s = '0;
                    gv_nxt_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                    gv_nxt_s    = 1'b0;
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                    gv_nxt_s    = 1'b0;
                    to_nxt_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
                gv_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers; last starts at N-1 so the first search begins at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            last_r  <= SEL_W'(N - 1);
            gnt_r   <= '0;
            gv_r    <= 1'b0;
            to_r    <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            last_r  <= last_nxt_s;
            gnt_r   <= gnt_nxt_s;
            gv_r    <= gv_nxt_s;
            to_r    <= to_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign sel       = sel_r;
    assign gnt       = gnt_r;
    assign gnt_valid = gv_r;
    assign timeout   = to_r;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus random
// traffic, all compared against a cycle-level reference model of the rules.
module tb_mux16_rr_sched;

    localparam int N        = 16;
    localparam int SEL_W    = 4;
    localparam int MAX_HOLD = 15;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic             gnt_valid;
    logic [N-1:0]     gnt;
    logic             timeout;

    int n_checks;
    int n_pass;

    // Reference model state
    bit m_busy;
    int m_sel;
    int m_last;
    int m_cnt;
    bit m_to;

    mux16_rr_sched #(
        .N        (N),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = N - 1;
        m_cnt  = 0;
        m_to   = 1'b0;
    endfunction

    function automatic void model_step();
        bit found;
        found = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            m_to = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (!found && req[i]) begin
                    found  = 1'b1;
                    m_sel  = i;
                    m_last = i;
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end else begin
            if (done || !req[m_sel]) begin
                m_busy = 1'b0;
                m_to   = 1'b0;
            end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1) begin
                m_busy = 1'b0;
                m_to   = 1'b1;
            end else begin
                m_cnt++;
                m_to = 1'b0;
            end
        end
    endfunction

    // One clock: model advances on the rising edge, outputs compared on the falling edge.
    task automatic tick();
        logic [31:0] exp_gnt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_gnt = m_busy ? (32'd1 << m_sel) : 32'd0;
        check("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_busy});
        check("gnt", {16'd0, gnt}, exp_gnt);
        check("sel", {28'd0, sel}, m_sel);
        check("timeout", {31'd0, timeout}, {31'd0, m_to});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int w;
        w = 0;
        while (!gnt_valid && w < 20) begin
            tick();
            w++;
        end
        check(tag, {31'd0, gnt_valid}, 32'd1);
    endtask

    // Hold req, pulse done 'delay' cycles into each grant; collect granted indices.
    task automatic run_done(input logic [N-1:0] r, input int delay, input int ngr,
                            output int sels[8], output int to_cnt);
        int  cnt;
        int  age;
        int  budget;
        bit  prev;
        cnt    = 0;
        age    = 0;
        budget = 0;
        to_cnt = 0;
        prev   = gnt_valid;
        for (int i = 0; i < 8; i++) sels[i] = -1;
        while (!(cnt == ngr && !gnt_valid) && budget < 300) begin
            req  = r;
            done = gnt_valid && (age == delay);
            tick();
            budget++;
            if (timeout) to_cnt++;
            if (gnt_valid && !prev) begin
                if (cnt < 8) sels[cnt] = sel;
                cnt++;
                age = 0;
            end else if (gnt_valid) begin
                age++;
            end
            prev = gnt_valid;
        end
        done = 1'b0;
        check("run_budget", {31'd0, (budget < 300)}, 32'd1);
    endtask

    initial begin
        int sels[8];
        int to_cnt;
        int run_len;
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Idle after reset with no requests
        for (int i = 0; i < 10; i++) tick();

        // Two requesters alternate
        run_done(16'h0101, 2, 4, sels, to_cnt);
        check("seq0101_0", sels[0], 0);
        check("seq0101_1", sels[1], 8);
        check("seq0101_2", sels[2], 0);
        check("seq0101_3", sels[3], 8);

        // Wrap-around fairness from a fresh pointer
        req = '0;
        apply_reset();
        run_done(16'hA110, 1, 5, sels, to_cnt);
        check("seqA110_0", sels[0], 4);
        check("seqA110_1", sels[1], 8);
        check("seqA110_2", sels[2], 13);
        check("seqA110_3", sels[3], 15);
        check("seqA110_4", sels[4], 4);
        req = '0;
        tick();
        tick();

        // Hold timeout with a single persistent requester
        req = 16'h0008;
        wait_grant("to_grant");
        run_len = 0;
        while (gnt_valid && run_len < 40) begin
            run_len++;
            tick();
        end
        check("hold_len", run_len, MAX_HOLD);
        check("to_pulse", {31'd0, timeout}, 32'd1);
        tick();
        check("regrant_valid", {31'd0, gnt_valid}, 32'd1);
        check("regrant_sel", {28'd0, sel}, 32'd3);
        req = '0;
        tick();
        tick();

        // Requester withdraws mid-grant
        req = 16'h0020;
        wait_grant("wd_grant");
        check("wd_sel", {28'd0, sel}, 32'd5);
        tick();
        tick();
        req = '0;
        tick();
        check("wd_valid", {31'd0, gnt_valid}, 32'd0);
        check("wd_to", {31'd0, timeout}, 32'd0);
        tick();

        // Done arriving on the last hold cycle is a normal release
        run_done(16'h0040, MAX_HOLD - 1, 1, sels, to_cnt);
        check("expiry_done_sel", sels[0], 6);
        check("expiry_done_to", to_cnt, 0);
        req = '0;
        tick();
        tick();

        // Asynchronous reset in the middle of a grant
        req = 16'h0201;
        wait_grant("mr_grant0");
        req = 16'h0200;
        tick();
        tick();
        wait_grant("mr_grant");
        check("mr_sel_pre", {28'd0, sel}, 32'd9);
        #2 rst = 1'b1;
        #1;
        check("mr_gv", {31'd0, gnt_valid}, 32'd0);
        check("mr_gnt", {16'd0, gnt}, 32'd0);
        check("mr_sel", {28'd0, sel}, 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        wait_grant("mr_regrant");
        check("mr_post_sel", {28'd0, sel}, 32'd9);

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(3, 0) == 0) req = N'($urandom & $urandom);
            done = ($urandom_range(4, 0) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
